// File: rtl/tl_uh_pkg.sv
// Shared TileLink-UH constants and arbiter state encoding used by the
// RAM arbiter and its round-robin picker.
package tl_uh_pkg;

  // A-channel opcodes
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;

  // D-channel opcodes
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Beats per 64B burst on a 64-bit bus
  localparam int TL_BEATS = 8;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_ACT  = 2'd1,
    ST_D_RESP = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_uh_ram_arbiter_rr_pick.sv
// Combinational round-robin priority picker: returns the first asserted
// request found scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick
  import tl_uh_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    idx,
  output logic             any
);

  // One extra bit so ptr + offset cannot overflow before the modulo step
  localparam int          SW = OW + 1;
  localparam logic [SW-1:0] NQ = SW'(N_REQ);

  logic [SW-1:0] sum_s;
  logic [OW-1:0] cand_s;

  // Scan from the pointer and keep the first requester that is asserted
  always_comb begin
    idx    = {OW{1'b0}};
    any    = 1'b0;
    sum_s  = {SW{1'b0}};
    cand_s = {OW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, ptr} + SW'(i);
      if (sum_s >= NQ) begin
        sum_s = sum_s - NQ;
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[OW-1:0];
      if (!any && req[cand_s]) begin
        idx = cand_s;
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/tl_uh_ram_arbiter.sv
// Round-robin arbiter sharing one serialized TL-UH RAM slave between
// N_REQ requesters. One transaction is in flight at a time: the grant is
// held across the whole A burst and released after the last D beat.
module tl_uh_ram_arbiter
  import tl_uh_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int BEATS  = TL_BEATS
) (
  input  logic                      clk,
  input  logic                      rst,
  // Requester side, A channel (requester i at slot i of each packed bus)
  input  logic [N_REQ*3-1:0]        m_a_opcode,
  input  logic [N_REQ*3-1:0]        m_a_param,
  input  logic [N_REQ*3-1:0]        m_a_size,
  input  logic [N_REQ*4-1:0]        m_a_source,
  input  logic [N_REQ*ADDR_W-1:0]   m_a_address,
  input  logic [N_REQ*8-1:0]        m_a_mask,
  input  logic [N_REQ*DATA_W-1:0]   m_a_data,
  input  logic [N_REQ-1:0]          m_a_valid,
  output logic [N_REQ-1:0]          m_a_ready,
  // Requester side, D channel (payload broadcast, valid one-hot)
  output logic [2:0]                m_d_opcode,
  output logic [1:0]                m_d_param,
  output logic [2:0]                m_d_size,
  output logic [3:0]                m_d_source,
  output logic [1:0]                m_d_sink,
  output logic                      m_d_denied,
  output logic [DATA_W-1:0]         m_d_data,
  output logic                      m_d_corrupt,
  output logic [N_REQ-1:0]          m_d_valid,
  input  logic [N_REQ-1:0]          m_d_ready,
  // Slave side, A channel
  output logic [2:0]                s_a_opcode,
  output logic [2:0]                s_a_param,
  output logic [2:0]                s_a_size,
  output logic [3:0]                s_a_source,
  output logic [ADDR_W-1:0]         s_a_address,
  output logic [7:0]                s_a_mask,
  output logic [DATA_W-1:0]         s_a_data,
  output logic                      s_a_valid,
  input  logic                      s_a_ready,
  // Slave side, D channel
  input  logic [2:0]                s_d_opcode,
  input  logic [1:0]                s_d_param,
  input  logic [2:0]                s_d_size,
  input  logic [3:0]                s_d_source,
  input  logic [1:0]                s_d_sink,
  input  logic                      s_d_denied,
  input  logic [DATA_W-1:0]         s_d_data,
  input  logic                      s_d_corrupt,
  input  logic                      s_d_valid,
  output logic                      s_d_ready,
  // Status
  output logic [owner_w(N_REQ)-1:0] owner,
  output logic                      busy,
  output logic                      err_unexpected_d
);

  localparam int         OW       = owner_w(N_REQ);
  localparam logic [3:0] BEATS_L  = 4'(BEATS);
  localparam logic [3:0] BEATS_M1 = 4'(BEATS - 1);

  arb_state_e    state_r;
  logic [OW-1:0] owner_r;
  logic [OW-1:0] rr_ptr_r;
  logic [3:0]    a_left_r;
  logic [3:0]    d_left_r;
  logic          err_r;

  logic [OW-1:0] pick_idx_s;
  logic          pick_any_s;
  logic [OW-1:0] next_ptr_s;
  logic          a_hs_s;
  logic          d_hs_s;

  // Per-requester views of the packed A-channel buses
  logic [2:0]        a_opcode_s  [N_REQ];
  logic [2:0]        a_param_s   [N_REQ];
  logic [2:0]        a_size_s    [N_REQ];
  logic [3:0]        a_source_s  [N_REQ];
  logic [ADDR_W-1:0] a_address_s [N_REQ];
  logic [7:0]        a_mask_s    [N_REQ];
  logic [DATA_W-1:0] a_data_s    [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_opcode_s[g]  = m_a_opcode[3*g +: 3];
    assign a_param_s[g]   = m_a_param[3*g +: 3];
    assign a_size_s[g]    = m_a_size[3*g +: 3];
    assign a_source_s[g]  = m_a_source[4*g +: 4];
    assign a_address_s[g] = m_a_address[ADDR_W*g +: ADDR_W];
    assign a_mask_s[g]    = m_a_mask[8*g +: 8];
    assign a_data_s[g]    = m_a_data[DATA_W*g +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_rr_pick (
    .req (m_a_valid),
    .ptr (rr_ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign next_ptr_s = (owner_r == OW'(N_REQ - 1)) ? {OW{1'b0}} : (owner_r + OW'(1));
  assign a_hs_s     = (state_r == ST_A_ACT)  && m_a_valid[owner_r] && s_a_ready;
  assign d_hs_s     = (state_r == ST_D_RESP) && s_d_valid && m_d_ready[owner_r];

  // D payload is broadcast; only the valid is steered to the owner
  assign m_d_opcode  = s_d_opcode;
  assign m_d_param   = s_d_param;
  assign m_d_size    = s_d_size;
  assign m_d_source  = s_d_source;
  assign m_d_sink    = s_d_sink;
  assign m_d_denied  = s_d_denied;
  assign m_d_data    = s_d_data;
  assign m_d_corrupt = s_d_corrupt;

  assign owner            = owner_r;
  assign busy             = (state_r != ST_IDLE);
  assign err_unexpected_d = err_r;

  // Steer the owner's A channel to the slave and the slave's D valid/ready to the owner
  always_comb begin
    s_a_opcode  = a_opcode_s[owner_r];
    s_a_param   = a_param_s[owner_r];
    s_a_size    = a_size_s[owner_r];
    s_a_source  = a_source_s[owner_r];
    s_a_address = a_address_s[owner_r];
    s_a_mask    = a_mask_s[owner_r];
    s_a_data    = a_data_s[owner_r];
    s_a_valid   = 1'b0;
    m_a_ready   = {N_REQ{1'b0}};
    m_d_valid   = {N_REQ{1'b0}};
    s_d_ready   = 1'b0;
    case (state_r)
      ST_A_ACT: begin
        s_a_valid          = m_a_valid[owner_r];
        m_a_ready[owner_r] = s_a_ready;
      end
      ST_D_RESP: begin
        m_d_valid[owner_r] = s_d_valid;
        s_d_ready          = m_d_ready[owner_r];
      end
      default: begin
        s_a_valid = 1'b0;
      end
    endcase
  end

  // Arbitration FSM, burst beat counters and sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= {OW{1'b0}};
      rr_ptr_r <= {OW{1'b0}};
      a_left_r <= 4'd0;
      d_left_r <= 4'd0;
      err_r    <= 1'b0;
    end else begin
      // A D beat outside the response phase is dropped and flagged
      if (s_d_valid && (state_r != ST_D_RESP)) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            owner_r  <= pick_idx_s;
            a_left_r <= 4'd0;
            state_r  <= ST_A_ACT;
          end
        end
        ST_A_ACT: begin
          if (a_hs_s) begin
            if (a_left_r == 4'd0) begin
              // Opcode is only meaningful on the first beat of a burst
              if (s_a_opcode == TL_A_GET) begin
                d_left_r <= BEATS_L;
                state_r  <= ST_D_RESP;
              end else if ((s_a_opcode == TL_A_PUT_FULL) && (BEATS_L > 4'd1)) begin
                a_left_r <= BEATS_M1;
              end else begin
                d_left_r <= 4'd1;
                state_r  <= ST_D_RESP;
              end
            end else if (a_left_r == 4'd1) begin
              a_left_r <= 4'd0;
              d_left_r <= 4'd1;
              state_r  <= ST_D_RESP;
            end else begin
              a_left_r <= a_left_r - 4'd1;
            end
          end
        end
        ST_D_RESP: begin
          if (d_hs_s) begin
            if (d_left_r <= 4'd1) begin
              d_left_r <= 4'd0;
              rr_ptr_r <= next_ptr_s;
              state_r  <= ST_IDLE;
            end else begin
              d_left_r <= d_left_r - 4'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_uh_ram_arbiter.sv
// Directed bench for tl_uh_ram_arbiter with a behavioural RAM slave.
// Expected D beats are queued as stimulus is issued; a monitor pops and
// compares each beat as it is handed to a requester.
module tb_tl_uh_ram_arbiter;
  import tl_uh_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*3-1:0]  m_a_opcode, m_a_param, m_a_size;
  logic [N*4-1:0]  m_a_source;
  logic [N*AW-1:0] m_a_address;
  logic [N*8-1:0]  m_a_mask;
  logic [N*DW-1:0] m_a_data;
  logic [N-1:0]    m_a_valid, m_a_ready;
  logic [2:0]      m_d_opcode, m_d_size;
  logic [1:0]      m_d_param, m_d_sink;
  logic [3:0]      m_d_source;
  logic            m_d_denied, m_d_corrupt;
  logic [DW-1:0]   m_d_data;
  logic [N-1:0]    m_d_valid, m_d_ready;
  logic [2:0]      s_a_opcode, s_a_param, s_a_size;
  logic [3:0]      s_a_source;
  logic [AW-1:0]   s_a_address;
  logic [7:0]      s_a_mask;
  logic [DW-1:0]   s_a_data;
  logic            s_a_valid, s_a_ready;
  logic [2:0]      s_d_opcode, s_d_size;
  logic [1:0]      s_d_param, s_d_sink;
  logic [3:0]      s_d_source;
  logic            s_d_denied, s_d_corrupt;
  logic [DW-1:0]   s_d_data;
  logic            s_d_valid, s_d_ready;
  logic [0:0]      owner;
  logic            busy, err_unexpected_d;

  tl_uh_ram_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .BEATS(8)) dut (
    .clk(clk), .rst(rst),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
    .m_a_data(m_a_data), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_sink(m_d_sink), .m_d_denied(m_d_denied),
    .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid),
    .m_d_ready(m_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_denied(s_d_denied),
    .s_d_data(s_d_data), .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid),
    .s_d_ready(s_d_ready),
    .owner(owner), .busy(busy), .err_unexpected_d(err_unexpected_d)
  );

  int n_vec = 0;
  int n_bad = 0;
  int beats_seen = 0;
  int wr_count = 0;
  int leak = 0;
  logic inject_d = 1'b0;

  typedef struct {
    int         r;
    logic [2:0] op;
    logic [63:0] data;
    bit         chk_data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_get(input int r, input logic [63:0] d0);
    for (int k = 0; k < 8; k++) sb.push_back('{r, TL_D_ACCESS_ACK_DATA, d0 + 64'(k), 1'b1});
  endtask

  task automatic exp_ack(input int r);
    sb.push_back('{r, TL_D_ACCESS_ACK, 64'd0, 1'b0});
  endtask

  // ---------------- behavioural RAM slave ----------------
  logic [63:0] mem [64];
  initial begin
    int  d_left, d_idx, put_left, put_idx, base;
    logic [2:0] d_op;
    bit  a_hs, d_hs, rst_smp;
    logic [2:0]  a_op;
    logic [63:0] a_addr, a_dat;
    for (int i = 0; i < 64; i++) mem[i] = 64'(i);
    d_left = 0; d_idx = 0; put_left = 0; put_idx = 0; base = 0; d_op = 3'd0;
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_opcode = 3'd0; s_d_param = 2'd0;
    s_d_size = 3'd6; s_d_source = 4'd0; s_d_sink = 2'd0; s_d_denied = 1'b0;
    s_d_corrupt = 1'b0; s_d_data = 64'd0;
    forever begin
      @(negedge clk);
      a_hs = s_a_valid && s_a_ready;
      d_hs = s_d_valid && s_d_ready;
      a_op = s_a_opcode; a_addr = s_a_address; a_dat = s_a_data;
      rst_smp = rst;
      @(posedge clk);
      #1;
      if (rst_smp) begin
        d_left = 0; put_left = 0;
      end else begin
        if (d_hs && d_left != 0) begin d_left--; d_idx++; end
        if (a_hs) begin
          if (put_left == 0) begin
            base = int'(a_addr >> 3) & 63;
            if (a_op == TL_A_GET) begin
              d_left = 8; d_idx = 0; d_op = TL_D_ACCESS_ACK_DATA;
            end else if (a_op == TL_A_PUT_FULL) begin
              mem[base] = a_dat; wr_count++; put_idx = 1; put_left = 7;
            end else begin
              d_left = 1; d_idx = 0; d_op = TL_D_ACCESS_ACK;
            end
          end else begin
            mem[(base + put_idx) & 63] = a_dat; wr_count++; put_idx++; put_left--;
            if (put_left == 0) begin d_left = 1; d_idx = 0; d_op = TL_D_ACCESS_ACK; end
          end
        end
      end
      s_a_ready  = (d_left == 0);
      s_d_valid  = (d_left != 0) || inject_d;
      s_d_opcode = d_op;
      s_d_data   = (d_op == TL_D_ACCESS_ACK_DATA) ? mem[(base + d_idx) & 63] : 64'd0;
    end
  end

  // ---------------- D-channel monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (m_a_ready[r] && !(busy && int'(owner) == r)) leak++;
      end
      if (m_d_valid != '0) chk("d_valid_onehot", 64'($onehot0(m_d_valid)), 64'd1);
      for (int r = 0; r < N; r++) begin
        if (m_d_valid[r] && m_d_ready[r]) begin
          if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL d_unexpected: got beat for req %0d, want none", r);
          end else begin
            e = sb.pop_front();
            chk("d_req", 64'(r), 64'(e.r));
            chk("d_opcode", 64'(m_d_opcode), 64'(e.op));
            if (e.chk_data) chk("d_data", m_d_data, e.data);
            beats_seen++;
          end
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic set_a(input int r, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] data, input logic v);
    m_a_opcode[3*r +: 3]    = op;
    m_a_param[3*r +: 3]     = 3'd0;
    m_a_size[3*r +: 3]      = 3'd6;
    m_a_source[4*r +: 4]    = 4'(r);
    m_a_address[AW*r +: AW] = addr;
    m_a_mask[8*r +: 8]      = 8'hFF;
    m_a_data[DW*r +: DW]    = data;
    m_a_valid[r]            = v;
  endtask

  task automatic req_xfer(input int r, input logic [2:0] op, input logic [63:0] addr,
                          input int nbeats, input logic [63:0] d0, input int stall_at);
    int beat = 0;
    int waited = 0;
    bit hs;
    @(posedge clk); #1;
    set_a(r, op, addr, d0, 1'b1);
    while (beat < nbeats) begin
      @(negedge clk);
      hs = m_a_ready[r];
      @(posedge clk); #1;
      if (hs) begin
        beat++;
        waited = 0;
        if (beat == stall_at && beat < nbeats) begin
          m_a_valid[r] = 1'b0;
          repeat (2) begin
            @(negedge clk);
            chk("stall_owner", 64'(owner), 64'(r));
            chk("stall_busy", 64'(busy), 64'd1);
            chk("stall_s_a_valid", 64'(s_a_valid), 64'd0);
            @(posedge clk); #1;
          end
          m_a_valid[r] = 1'b1;
        end
        m_a_data[DW*r +: DW] = d0 + 64'(beat);
      end else begin
        waited++;
        if (waited > 200) begin
          chk("a_grant_timeout", 64'(beat), 64'(nbeats));
          beat = nbeats;
        end
      end
    end
    m_a_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 400);
    if (n >= 400) chk("idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_beats(input int tgt);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (beats_seen < tgt && n < 200);
    if (n >= 200) chk("beat_timeout", 64'(beats_seen), 64'(tgt));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, wr0;
    rst = 1'b1;
    m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
    m_a_address = '0; m_a_mask = '0; m_a_data = '0; m_a_valid = '0;
    m_d_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
    chk("rst_m_d_valid", 64'(m_d_valid), 64'd0);
    chk("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_err", 64'(err_unexpected_d), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single Get from req0 at 0x40: data 8..15
    exp_get(0, 64'd8);
    base = beats_seen;
    fork
      req_xfer(0, TL_A_GET, 64'h40, 1, 64'd0, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("arb_lat_s_a_valid_lo", 64'(s_a_valid), 64'd0);
        @(negedge clk);
        chk("arb_lat_s_a_valid_hi", 64'(s_a_valid), 64'd1);
        chk("arb_lat_owner", 64'(owner), 64'd0);
      end
    join
    wait_beats(base + 8);
    @(negedge clk);
    chk("busy_after_last", 64'(busy), 64'd0);
    wait_idle();

    // Simultaneous pairs after reset: order 0,1,0,1,...
    do_reset();
    for (int rnd = 0; rnd < 4; rnd++) begin
      exp_get(0, 64'd0);
      exp_get(1, 64'd8);
      fork
        req_xfer(0, TL_A_GET, 64'h00, 1, 64'd0, 0);
        req_xfer(1, TL_A_GET, 64'h40, 1, 64'd0, 0);
      join
      wait_idle();
    end

    // Put from req1 while req0 waits with a Get to the same line
    exp_ack(1);
    exp_get(0, 64'hA0);
    fork
      req_xfer(1, TL_A_PUT_FULL, 64'h80, 8, 64'hA0, 0);
      begin
        repeat (2) @(posedge clk);
        req_xfer(0, TL_A_GET, 64'h80, 1, 64'd0, 0);
      end
    join
    wait_idle();

    // D backpressure: owner holds m_d_ready low for 3 cycles mid-burst
    exp_get(0, 64'd8);
    base = beats_seen;
    fork
      req_xfer(0, TL_A_GET, 64'h40, 1, 64'd0, 0);
      begin
        wait_beats(base + 3);
        #1 m_d_ready[0] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_s_d_ready", 64'(s_d_ready), 64'd0);
          chk("bp_m_d_valid", 64'(m_d_valid[0]), 64'd1);
          @(posedge clk);
        end
        #1 m_d_ready[0] = 1'b1;
      end
    join
    wait_idle();

    // A-side stall between Put beats 3 and 4, then read back
    wr0 = wr_count;
    exp_ack(1);
    req_xfer(1, TL_A_PUT_FULL, 64'h100, 8, 64'h55, 3);
    wait_idle();
    chk("put_writes", 64'(wr_count - wr0), 64'd8);
    exp_get(1, 64'h55);
    req_xfer(1, TL_A_GET, 64'h100, 1, 64'd0, 0);
    wait_idle();

    // Unexpected D beat in IDLE sets the sticky error
    inject_d = 1'b1;
    @(negedge clk);
    chk("inject_s_d_ready", 64'(s_d_ready), 64'd0);
    chk("inject_no_route", 64'(m_d_valid), 64'd0);
    inject_d = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(err_unexpected_d), 64'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err_unexpected_d), 64'd1);

    // Reset during D beat 4 of a Get owned by req1
    exp_get(1, 64'd8);
    base = beats_seen;
    req_xfer(1, TL_A_GET, 64'h40, 1, 64'd0, 0);
    wait_beats(base + 3);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_owner", 64'(owner), 64'd0);
    chk("mid_rst_err", 64'(err_unexpected_d), 64'd0);
    chk("mid_rst_m_d_valid", 64'(m_d_valid), 64'd0);

    // Recovery after reset
    exp_get(0, 64'd0);
    req_xfer(0, TL_A_GET, 64'h00, 1, 64'd0, 0);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("a_ready_leak", 64'(leak), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_uh_ram_arbiter.md
Name: tl_uh_ram_arbiter

Overview:
Round-robin arbiter that shares one TL-UH slave (the simple RAM model: 8-beat 64B bursts, Get/PutFullData) between N_REQ requesters on the system testbench interconnect.
It grants the A channel per transaction and locks the grant for the full PutFullData burst. It then routes every D beat back to the granted requester and releases the grant after the last D beat.
Only one transaction is outstanding at a time, which matches the slave's serialized operation.

Parameters:
N_REQ, 2, number of requesters (2..4)
DATA_W, 64, data width
ADDR_W, 64, address width
BEATS, 8, beats per burst (Get response and PutFullData request)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_a_opcode  in  N_REQ*3  per-requester A opcode (packed, requester i at [3i+:3]; same packing below)
m_a_param  in  N_REQ*3  A param
m_a_size  in  N_REQ*3  A size
m_a_source  in  N_REQ*4  A source
m_a_address  in  N_REQ*ADDR_W  A address
m_a_mask  in  N_REQ*8  A mask
m_a_data  in  N_REQ*DATA_W  A data
m_a_valid  in  N_REQ  A valid
m_a_ready  out  N_REQ  A ready
m_d_opcode  out  3  D opcode, broadcast
m_d_param  out  2  D param, broadcast
m_d_size  out  3  D size, broadcast
m_d_source  out  4  D source, broadcast
m_d_sink  out  2  D sink, broadcast
m_d_denied  out  1  D denied, broadcast
m_d_data  out  DATA_W  D data, broadcast
m_d_corrupt  out  1  D corrupt, broadcast
m_d_valid  out  N_REQ  D valid, one-hot to owner
m_d_ready  in  N_REQ  D ready
s_a_*  out  as above (single)  A channel to slave
s_a_valid  out  1  A valid to slave
s_a_ready  in  1  A ready from slave
s_d_*  in  as above (single)  D channel from slave
s_d_valid  in  1  D valid from slave
s_d_ready  out  1  D ready to slave
owner  out  $clog2(N_REQ) (min 1)  current/last grant index
busy  out  1  state != IDLE
err_unexpected_d  out  1  sticky protocol error

Behaviour:
- States: IDLE, A_ACT, D_RESP. Registers: state, owner, rr_ptr, a_left (4b), d_left (4b), err.
- Reset: all registers go to 0 (state=IDLE). Outputs at reset: s_a_valid=0, m_a_ready=0, m_d_valid=0, s_d_ready=0, busy=0, owner=0, err_unexpected_d=0.
- Reset mid-transaction aborts to IDLE. No completion is owed; the slave is reset on the same edge.
- IDLE:
  - No forwarding: s_a_valid=0, all m_a_ready=0.
  - If any m_a_valid is set, latch owner = first set index scanning rr_ptr, rr_ptr+1, … mod N_REQ, then go to A_ACT.
  - Arbitration latency is 1 cycle, so the grant is stable before s_a_valid rises.
- A_ACT:
  - s_a_* = owner's m_a_*; s_a_valid = m_a_valid[owner]; m_a_ready[owner] = s_a_ready; other m_a_ready=0.
  - On the first handshake (a_left==0):
    - Get (4): go to D_RESP with d_left = BEATS.
    - PutFullData (0): a_left = BEATS-1, stay in A_ACT.
    - Any other opcode: single beat, go to D_RESP with d_left = 1.
  - Later handshakes decrement a_left. When the handshake occurs with a_left==1, go to D_RESP with d_left = 1.
  - Opcode is sampled only on the first beat.
- D_RESP:
  - m_d_* = s_d_*; m_d_valid[owner] = s_d_valid; s_d_ready = m_d_ready[owner]; other m_d_valid=0.
  - Each D handshake decrements d_left. The handshake with d_left==1 goes to IDLE and sets rr_ptr = owner+1 mod N_REQ.
  - The new grant is therefore decided the cycle after the last D beat.
- s_d_ready=0 outside D_RESP.
- s_d_valid=1 outside D_RESP sets err (sticky until rst); the beat is dropped and not routed.
- Non-owners see m_a_ready=0 throughout; their requests stay pending, with no starvation under round-robin.
- Counters never wrap: a_left and d_left ≤ BEATS ≤ 15.

Decomposition:
- Shared package tl_uh_pkg: opcode constants (GET=4, PUT_FULL=0, ACCESS_ACK=0, ACCESS_ACK_DATA=1), BEATS default, state encoding localparams.
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, ptr → index, any).

Test Plan:
- Single Get from req0 at addr 0x40:
  - s_a_valid rises 1 cycle after m_a_valid[0].
  - req0 receives 8 D beats with data 8..15; m_d_valid[1] stays 0; busy drops after the 8th beat.
- Simultaneous Get from req0 and req1 after reset:
  - req0 is served first, then req1.
  - A second simultaneous pair is served req1 first? No: rr_ptr=0 after req1, so req0 is served first again.
  - Check order 0,1,0,1 over 4 back-to-back rounds.
- PutFullData 8 beats from req1 at 0x80 with data 0xA0..0xA7, while req0 holds a Get valid:
  - req0's m_a_ready stays 0 during all 8 A beats and the 1 AccessAck.
  - A follow-up Get by req0 at 0x80 returns 0xA0..0xA7.
- D backpressure: owner holds m_d_ready=0 for 3 cycles mid-burst.
  - s_d_ready=0 over the same cycles; no beat is lost or duplicated; all 8 beats arrive in order.
- A_ACT stall: owner drops m_a_valid between Put beats 3 and 4 for 2 cycles.
  - The grant is held, a_left is unchanged, and the burst completes with 8 writes.
- Protocol and reset:
  - Force s_d_valid=1 in IDLE: err_unexpected_d=1 and stays 1.
  - Assert rst during D_RESP beat 4: the next cycle shows state IDLE, owner=0, err_unexpected_d=0.
